// File: rtl/soundrive_dac.sv
// soundrive_dac: sums covox/soundrive channel pairs, paces them at a fixed sample rate and
// drives per-side 1-bit sigma-delta outputs behind an anti-pop ramp. Option: SOUNDRIVE_DAC_DITHER_EN.
module soundrive_dac #(
    parameter int unsigned SAMPLE_DIV    = 640,
    parameter int unsigned RAMP_STEP_DIV = 64
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] ch_l0,
    input  logic [7:0] ch_l1,
    input  logic [7:0] ch_r0,
    input  logic [7:0] ch_r1,
    output logic       dac_l,
    output logic       dac_r,
    output logic       sample_stb,
    output logic       ramp_done
);
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned MIX_W  = 9;
    localparam int unsigned ACC_W  = 10;
    localparam logic [MIX_W-1:0] RAMP_TOP = MIX_W'(256);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    logic [CNT_W-1:0]  sample_cnt;
    logic [MIX_W-1:0]  mix_l;
    logic [MIX_W-1:0]  mix_r;
    state_t            state;
    logic [MIX_W-1:0]  ramp;
    logic [STEP_W-1:0] step_cnt;
    logic              step;
    logic [MIX_W-1:0]  level_l;
    logic [MIX_W-1:0]  level_r;
    logic              cin;
    logic [ACC_W-1:0]  acc_l;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  sum_l;
    logic [ACC_W-1:0]  sum_r;

    // Sample pacing: channel pairs are latched only at the counter's terminal count
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            sample_stb <= 1'b0;
            mix_l      <= '0;
            mix_r      <= '0;
        end else if (sample_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            sample_cnt <= '0;
            sample_stb <= 1'b1;
            mix_l      <= MIX_W'(ch_l0) + MIX_W'(ch_l1);
            mix_r      <= MIX_W'(ch_r0) + MIX_W'(ch_r1);
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            sample_stb <= 1'b0;
        end
    end

    assign step = (step_cnt == STEP_W'(RAMP_STEP_DIV - 1));

    // Anti-pop ramp FSM; an en change takes priority over a coincident step
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            ramp      <= '0;
            step_cnt  <= '0;
            ramp_done <= 1'b0;
        end else begin
            step_cnt <= step ? '0 : step_cnt + STEP_W'(1);
            case (state)
                ST_OFF: begin
                    ramp <= '0;
                    if (en) begin
                        state    <= ST_RAMP_UP;
                        step_cnt <= '0;
                    end
                end
                ST_RAMP_UP: begin
                    if (!en) begin
                        state    <= ST_RAMP_DOWN;
                        step_cnt <= '0;
                    end else if (ramp == RAMP_TOP) begin
                        state     <= ST_RUN;
                        step_cnt  <= '0;
                        ramp_done <= 1'b1;
                    end else if (step) begin
                        ramp <= ramp + MIX_W'(1);
                    end
                end
                ST_RUN: begin
                    ramp <= RAMP_TOP;
                    if (!en) begin
                        state     <= ST_RAMP_DOWN;
                        step_cnt  <= '0;
                        ramp_done <= 1'b0;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (en) begin
                        state    <= ST_RAMP_UP;
                        step_cnt <= '0;
                    end else if (ramp == '0) begin
                        state    <= ST_OFF;
                        step_cnt <= '0;
                    end else if (step) begin
                        ramp <= ramp - MIX_W'(1);
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    ramp      <= '0;
                    step_cnt  <= '0;
                    ramp_done <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        level_l = ramp;
        level_r = ramp;
        if (state == ST_RUN) begin
            level_l = mix_l;
            level_r = mix_r;
        end
    end

`ifdef SOUNDRIVE_DAC_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; carry-in suppressed in OFF to keep silence exact
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cin = (state != ST_OFF) & lfsr[0];
`else
    assign cin = 1'b0;
`endif

    assign sum_l = {1'b0, acc_l[MIX_W-1:0]} + ACC_W'(level_l) + ACC_W'(cin);
    assign sum_r = {1'b0, acc_r[MIX_W-1:0]} + ACC_W'(level_r) + ACC_W'(cin);

    // First-order sigma-delta: the carry out of the 9-bit accumulator is the bitstream
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            acc_l <= '0;
            acc_r <= '0;
            dac_l <= 1'b0;
            dac_r <= 1'b0;
        end else begin
            acc_l <= sum_l;
            acc_r <= sum_r;
            dac_l <= sum_l[ACC_W-1];
            dac_r <= sum_r[ACC_W-1];
        end
    end

endmodule

// File: tb/tb_soundrive_dac.sv
// Bench for soundrive_dac: cycle reference model compared every clock, table-driven RUN
// density vectors, and hand-written ramp, pacing, reversal, fade and async-reset sequences.
`timescale 1ns/1ps
module tb_soundrive_dac;
    localparam int SAMPLE_DIV    = 640;
    localparam int RAMP_STEP_DIV = 64;
    localparam int RAMP_FULL     = 256;
    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_RUN  = 2;
    localparam int M_DOWN = 3;

    logic       clk28 = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] ch_l0 = 8'h80;
    logic [7:0] ch_l1 = 8'h80;
    logic [7:0] ch_r0 = 8'h80;
    logic [7:0] ch_r1 = 8'h80;
    logic       dac_l;
    logic       dac_r;
    logic       sample_stb;
    logic       ramp_done;

    soundrive_dac #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .RAMP_STEP_DIV(RAMP_STEP_DIV)
    ) dut (
        .clk28     (clk28),
        .rst       (rst),
        .en        (en),
        .ch_l0     (ch_l0),
        .ch_l1     (ch_l1),
        .ch_r0     (ch_r0),
        .ch_r1     (ch_r1),
        .dac_l     (dac_l),
        .dac_r     (dac_r),
        .sample_stb(sample_stb),
        .ramp_done (ramp_done)
    );

    always #18 clk28 = ~clk28;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain integers following the behavioural rules
    int m_mode, m_ramp, m_since, m_scnt, m_mix_l, m_mix_r, m_acc_l, m_acc_r;
    bit m_dac_l, m_dac_r, m_stb, m_done;

    typedef struct {
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] r0;
        logic [7:0] r1;
        int         exp_l;
        int         exp_r;
    } vec_t;

    vec_t vecs[8];

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
            if (errors >= 50) finish_run();
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
            if (errors >= 50) finish_run();
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_ramp = 0; m_since = 0; m_scnt = 0;
        m_mix_l = 0; m_mix_r = 0; m_acc_l = 0; m_acc_r = 0;
        m_dac_l = 1'b0; m_dac_r = 1'b0; m_stb = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_enter(input int mode);
        m_mode  = mode;
        m_since = 0;
    endtask

    task automatic model_step();
        int lvl_l, lvl_r, s;
        bit stepped;
        lvl_l = (m_mode == M_RUN) ? m_mix_l : m_ramp;
        lvl_r = (m_mode == M_RUN) ? m_mix_r : m_ramp;
        s = (m_acc_l % 512) + lvl_l;
        m_dac_l = (s >= 512);
        m_acc_l = s;
        s = (m_acc_r % 512) + lvl_r;
        m_dac_r = (s >= 512);
        m_acc_r = s;
        if (m_scnt == SAMPLE_DIV - 1) begin
            m_stb   = 1'b1;
            m_scnt  = 0;
            m_mix_l = int'(ch_l0) + int'(ch_l1);
            m_mix_r = int'(ch_r0) + int'(ch_r1);
        end else begin
            m_stb  = 1'b0;
            m_scnt = m_scnt + 1;
        end
        stepped = ((m_since % RAMP_STEP_DIV) == RAMP_STEP_DIV - 1);
        m_since = m_since + 1;
        case (m_mode)
            M_OFF:  if (en) model_enter(M_UP);
            M_UP: begin
                if (!en) model_enter(M_DOWN);
                else if (m_ramp == RAMP_FULL) model_enter(M_RUN);
                else if (stepped) m_ramp = m_ramp + 1;
            end
            M_RUN:  if (!en) model_enter(M_DOWN);
            default: begin
                if (en) model_enter(M_UP);
                else if (m_ramp == 0) model_enter(M_OFF);
                else if (stepped) m_ramp = m_ramp - 1;
            end
        endcase
        m_done = (m_mode == M_RUN);
    endtask

    // One clock: advance the model at the active edge, compare on the falling edge
    task automatic tick();
        @(posedge clk28);
        if (rst) model_reset();
        else model_step();
        @(negedge clk28);
        check("outputs", int'({dac_l, dac_r, sample_stb, ramp_done}),
              int'({m_dac_l, m_dac_r, m_stb, m_done}));
    endtask

    task automatic count_ones(input int n, output int nl, output int nr);
        nl = 0;
        nr = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            nl += int'(dac_l);
            nr += int'(dac_r);
        end
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_stb && n < SAMPLE_DIV + 8);
        check("stb_seen", int'(sample_stb), 1);
    endtask

    task automatic wait_ramp(input int target);
        int n;
        n = 0;
        while (m_ramp != target) begin
            tick();
            n++;
            if (n > 40000) begin
                $display("FAIL wait_ramp: model ramp %0d never reached %0d", m_ramp, target);
                $fatal(1);
            end
        end
    endtask

    task automatic set_ch(input logic [7:0] l0, input logic [7:0] l1,
                          input logic [7:0] r0, input logic [7:0] r1);
        ch_l0 = l0; ch_l1 = l1; ch_r0 = r0; ch_r1 = r1;
    endtask

    initial begin
        int nl, nr, prev, n, rise, bad, before_l, after_l;
        bit last;

        vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 510, 510};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
        vecs[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 256, 256};
        vecs[3] = '{8'h40, 8'h20, 8'h10, 8'hF0, 96, 256};
        vecs[4] = '{8'h01, 8'h00, 8'hFE, 8'h01, 1, 255};
        for (int i = 5; i < 8; i++) begin
            vecs[i].l0 = 8'($urandom_range(0, 255));
            vecs[i].l1 = 8'($urandom_range(0, 255));
            vecs[i].r0 = 8'($urandom_range(0, 255));
            vecs[i].r1 = 8'($urandom_range(0, 255));
            vecs[i].exp_l = int'(vecs[i].l0) + int'(vecs[i].l1);
            vecs[i].exp_r = int'(vecs[i].r0) + int'(vecs[i].r1);
        end

        model_reset();
        repeat (3) tick();
        check("reset_outputs", int'({dac_l, dac_r, sample_stb, ramp_done}), 0);

        // Ramp up from reset with mid-scale channels
        rst = 1'b0;
        en  = 1'b1;
        tick();
        prev = -1;
        for (int w = 0; w < 16; w++) begin
            count_ones(1024, nl, nr);
            if (w > 0) check_range("ramp_density_rise", nl, prev + 1, 1024);
            prev = nl;
        end
        rise = -1;
        for (int i = 1; i <= 8 && rise < 0; i++) begin
            tick();
            if (ramp_done) rise = RAMP_FULL * RAMP_STEP_DIV + i;
        end
        check_range("ramp_up_time", rise, RAMP_FULL * RAMP_STEP_DIV - 1, RAMP_FULL * RAMP_STEP_DIV + 3);

        // RUN densities: a constant level L yields exactly L ones per 512 cycles
        for (int i = 0; i < 8; i++) begin
            set_ch(vecs[i].l0, vecs[i].l1, vecs[i].r0, vecs[i].r1);
            wait_stb(n);
            tick();
            count_ones(512, nl, nr);
            check("run_density_l", nl, vecs[i].exp_l);
            check("run_density_r", nr, vecs[i].exp_r);
        end

        // Pacing: strobe period, strict alternation, and latch-only-on-strobe
        set_ch(8'h80, 8'h80, 8'h80, 8'h80);
        wait_stb(n);
        wait_stb(n);
        check("stb_period", n, SAMPLE_DIV);
        bad = 0;
        tick();
        last = dac_l;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (dac_l == last) bad++;
            last = dac_l;
        end
        check("alternation", bad, 0);
        repeat (236) tick();
        ch_l0 = 8'hC0;
        count_ones(256, nl, nr);
        check("pacing_hold", nl, 128);
        wait_stb(n);
        tick();
        count_ones(512, nl, nr);
        check("pacing_new", nl, 8'hC0 + 8'h80);

        // Fade out to silence
        en = 1'b0;
        tick();
        check("fade_done_low", int'(ramp_done), 0);
        repeat (RAMP_FULL * RAMP_STEP_DIV + 8) tick();
        count_ones(1024, nl, nr);
        check("fade_silent_l", nl, 0);
        check("fade_silent_r", nr, 0);

        // Mid-ramp reversal at 100 and again at 40
        en = 1'b1;
        wait_ramp(92);
        count_ones(512, before_l, nr);
        wait_ramp(100);
        en = 1'b0;
        count_ones(512, after_l, nr);
        check_range("reversal_continuity", after_l - before_l, -8, 8);
        wait_ramp(40);
        en = 1'b1;
        tick();
        rise = -1;
        for (int i = 1; i <= 14000 && rise < 0; i++) begin
            tick();
            if (ramp_done) rise = i;
        end
        check_range("reversal_ramp_time", rise, (RAMP_FULL - 40) * RAMP_STEP_DIV - 1,
                    (RAMP_FULL - 40) * RAMP_STEP_DIV + 3);

        // Asynchronous reset in RUN, off the clock edge
        set_ch(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_stb(n);
        repeat (5) tick();
        #7 rst = 1'b1;
        #1 check("async_reset_out", int'({dac_l, dac_r, sample_stb, ramp_done}), 0);
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        count_ones(RAMP_STEP_DIV, nl, nr);
        check("restart_zero_l", nl, 0);
        check("restart_zero_r", nr, 0);

        // Random en toggles and channel changes against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0)
                set_ch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end

        finish_run();
    end

endmodule

// File: doc/soundrive_dac.md
Name: soundrive_dac

Overview:
- Downstream consumer of the four 8-bit covox/soundrive channel registers.
- Per side, sums the two channels, paces them into a fixed sample rate, and drives one-bit first-order sigma-delta outputs to the board's RC-filtered audio pins.
- Contains an anti-pop ramp state machine. Output fades from 0 up to the midpoint after reset or enable, and back down to 0 on disable.

Parameters:
- SAMPLE_DIV, 640: clk28 cycles per sample latch (28 MHz / 640 = 43.75 kHz); legal range 2..4095.
- RAMP_STEP_DIV, 64: clk28 cycles per ramp step of 1 LSB; legal range 1..255.

Ports:
- clk28  input  1  28 MHz system clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  1 = play, 0 = fade to silence
- ch_l0  input  8  left channel 0, unsigned, 0x80 = midpoint
- ch_l1  input  8  left channel 1
- ch_r0  input  8  right channel 0
- ch_r1  input  8  right channel 1
- dac_l  output  1  left sigma-delta bitstream
- dac_r  output  1  right sigma-delta bitstream
- sample_stb  output  1  one-cycle pulse when channels are latched
- ramp_done  output  1  1 while in RUN

Behaviour:
- Reset (rst=1, async): all outputs 0, sample counter 0, latches mix_l/mix_r 0, ramp 0, accumulators 0, state OFF. Reset mid-ramp returns to OFF.
- Sample pacing:
  - Counter runs 0..SAMPLE_DIV-1 and wraps to 0.
  - On the cycle the counter equals SAMPLE_DIV-1: sample_stb=1; mix_l <= ch_l0+ch_l1 and mix_r <= ch_r0+ch_r1, both 9-bit, range 0..510, no overflow possible.
  - Channel changes between strobes are ignored.
  - sample_stb is registered and coincides with the latch update.
- Ramp FSM (states OFF, RAMP_UP, RUN, RAMP_DOWN):
  - Ramp value is 9-bit, 0..256. A step-prescaler counter runs 0..RAMP_STEP_DIV-1; a "step" occurs at its terminal count.
  - OFF: level=0. en=1 -> RAMP_UP on the next cycle.
  - RAMP_UP: level=ramp. On each step, ramp+1. At ramp==256 -> RUN. en=0 -> RAMP_DOWN, keeping the current ramp.
  - RUN: level=mix_l/mix_r per side; ramp held at 256; ramp_done=1. en=0 -> RAMP_DOWN with ramp=256.
  - RAMP_DOWN: level=ramp. On each step, ramp-1. At ramp==0 -> OFF. en=1 -> RAMP_UP, keeping the current ramp.
  - The prescaler resets to 0 on every state change.
  - Full ramp time: 256 x RAMP_STEP_DIV cycles (16384 at default).
- Modulator (per side, every clk28 cycle):
  - acc is 10-bit; acc <= {1'b0, acc[8:0]} + level; dac <= carry, i.e. bit 9 of the sum.
  - Ones density = level/512.
  - dac is registered, one cycle after the sum.
  - level 0 gives a constant 0; level 256 alternates 0,1,0,1 starting from acc=0; level 510 gives 510 ones per 512 cycles.
- Simultaneous events: a strobe during RAMP_* still updates mix_l/mix_r (the new values are used once RUN is entered); an en toggle on a step cycle obeys the state transition, and the step is discarded.

Optional Feature:
- Macro: SOUNDRIVE_DAC_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 0xACE1, shifting every clk28 cycle.
  - lfsr[0] is added as carry-in to both accumulators: acc <= acc[8:0] + level + lfsr[0].
  - This breaks idle tones; the mean density rises by about 0.5/512.
  - In OFF state the carry-in is forced to 0, so the output stays a constant 0.
- Undefined: no LFSR logic; behaviour exactly as specified above.

Test Plan:
- Ramp up: assert rst, release with en=1 and all channels 0x80 -> ramp_done rises 1 + 16384 cycles after OFF exit (±2); during the ramp, dac_l density increases monotonically.
- RUN densities (no dither):
  - channels 0xFF -> 510 ones in each 512-cycle window.
  - channels 0x00 -> dac_l=dac_r=0 constant.
  - channels 0x80 -> strict 0/1 alternation.
- Pacing: change ch_l0 from 0x80 to 0xC0 mid-period -> the density change appears only after the next sample_stb; sample_stb period is exactly 640 cycles.
- Mid-ramp reversal: drop en when ramp=100 -> ramp decrements from 100; re-raise en at ramp=40 -> ramp increments from 40; no jump in level.
- Fade out: en=0 in RUN -> ramp_done=0 next cycle; OFF reached after 16384 cycles; dac outputs then stay 0.
- Reset mid-RUN: pulse rst asynchronously (not clock-aligned) -> all outputs 0 immediately; the ramp restarts from 0 after release.
